// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encodings, FSM states and stage count for the shift controller
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  localparam int STAGES = 5;
  // Counter starts at the top stage and walks down to bit 0 of shamt.
  localparam logic [2:0] CNT_LOAD = 3'(STAGES - 1);

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one conditional shift stage: shift by 2^k when en, fill chosen by op
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  op,
  input  logic [2:0]  k,
  input  logic        en,
  output logic [31:0] result
);

  logic [4:0] amt;

  always_comb begin
    amt    = 5'd1 << k;
    result = data;
    if (en) begin
      case (shift_op_e'(op))
        OP_SLL:  result = data << amt;
        OP_SRL:  result = data >> amt;
        OP_SRA:  result = 32'($signed(data) >>> amt);
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_controller.sv
// rtl/shift_controller.sv - two-port arbitrated, fixed-latency bit-serial-by-stage shifter
module shift_controller
  import shift_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [1:0]  req0_op_i,
  input  logic [31:0] req0_data_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [1:0]  req1_op_i,
  input  logic [31:0] req1_data_i,
  input  logic [4:0]  req1_shamt_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_id_o,
  output logic [31:0] resp_data_o
);

  state_e      state, state_nx;
  logic [1:0]  op_q;
  logic [31:0] work_q;
  logic [4:0]  shamt_q;
  logic [2:0]  cnt_q;
  logic        last_grant_q;
  logic        id_q;
  logic [31:0] resp_data_q;
  logic        grant0, grant1;
  logic        accept0, accept1, accept;
  logic [31:0] step_out;

  // last_grant_q == 1 means port 1 won last time, so port 0 gets the tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((RR_EN != 0) && req0_valid_i && req1_valid_i) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else if (req0_valid_i) begin
      grant0 = 1'b1;
    end else if (req1_valid_i) begin
      grant1 = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready_o = grant0 & ~rst_i;
        req1_ready_o = grant1 & ~rst_i;
        if ((req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o)) begin
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 3'd0) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign accept0 = req0_valid_i & req0_ready_o;
  assign accept1 = req1_valid_i & req1_ready_o;
  assign accept  = accept0 | accept1;

  shift_step u_step (
    .data   (work_q),
    .op     (op_q),
    .k      (cnt_q),
    .en     (shamt_q[cnt_q]),
    .result (step_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q         <= 2'b00;
      work_q       <= 32'd0;
      shamt_q      <= 5'd0;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      resp_data_q  <= 32'd0;
    end else if (accept) begin
      op_q         <= accept1 ? req1_op_i : req0_op_i;
      work_q       <= accept1 ? req1_data_i : req0_data_i;
      shamt_q      <= accept1 ? req1_shamt_i : req0_shamt_i;
      id_q         <= accept1;
      last_grant_q <= accept1;
      cnt_q        <= CNT_LOAD;
    end else if (state == ST_SHIFT) begin
      work_q <= step_out;
      // The last stage result goes straight into the response register.
      if (cnt_q == 3'd0) begin
        resp_data_q <= step_out;
      end else begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  assign resp_data_o = resp_data_q;
  assign resp_id_o   = id_q;

endmodule

// File: tb/tb_shift_controller.sv
// tb/tb_shift_controller.sv - self-checking bench for shift_controller in round-robin and fixed-priority builds
module tb_shift_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1;
  logic [1:0]  op0, op1;
  logic [31:0] d0, d1;
  logic [4:0]  s0, s1;
  logic        resp_ready;

  logic        rr_rdy0, rr_rdy1, rr_rv, rr_rid;
  logic [31:0] rr_rdata;
  logic        fp_rdy0, fp_rdy1, fp_rv, fp_rid;
  logic [31:0] fp_rdata;

  int n_checks = 0;
  int n_err    = 0;
  bit last_rr  = 1'b1;

  always #5 clk = ~clk;

  shift_controller #(.RR_EN(1)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(rr_rdy0), .req0_op_i(op0), .req0_data_i(d0), .req0_shamt_i(s0),
    .req1_valid_i(v1), .req1_ready_o(rr_rdy1), .req1_op_i(op1), .req1_data_i(d1), .req1_shamt_i(s1),
    .resp_valid_o(rr_rv), .resp_ready_i(resp_ready), .resp_id_o(rr_rid), .resp_data_o(rr_rdata)
  );

  shift_controller #(.RR_EN(0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(fp_rdy0), .req0_op_i(op0), .req0_data_i(d0), .req0_shamt_i(s0),
    .req1_valid_i(v1), .req1_ready_o(fp_rdy1), .req1_op_i(op1), .req1_data_i(d1), .req1_shamt_i(s1),
    .resp_valid_o(fp_rv), .resp_ready_i(resp_ready), .resp_id_o(fp_rid), .resp_data_o(fp_rdata)
  );

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] d, logic [4:0] s);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rr_rv"},    rr_rv,    0);
    check({tag, "_rr_rdata"}, rr_rdata, 0);
    check({tag, "_rr_rid"},   rr_rid,   0);
    check({tag, "_rr_rdy"},   {rr_rdy1, rr_rdy0}, 0);
    check({tag, "_fp_rv"},    fp_rv,    0);
    check({tag, "_fp_rdata"}, fp_rdata, 0);
    check({tag, "_fp_rid"},   fp_rid,   0);
    check({tag, "_fp_rdy"},   {fp_rdy1, fp_rdy0}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v0 = 1'b1;
    v1 = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    last_rr = 1'b1;
  endtask

  task automatic txn(input bit a0, input bit a1,
                     input logic [1:0] o0, input logic [31:0] x0, input logic [4:0] sh0,
                     input logic [1:0] o1, input logic [31:0] x1, input logic [4:0] sh1,
                     input int hold, input bit keep,
                     output bit g_rr, output bit g_fp);
    logic [31:0] exp_rr, exp_fp;
    int lat;
    v0 = a0; v1 = a1;
    op0 = o0; d0 = x0; s0 = sh0;
    op1 = o1; d1 = x1; s1 = sh1;
    resp_ready = 1'b0;
    g_rr = (a0 && a1) ? !last_rr : !a0;
    g_fp = !a0;
    exp_rr = g_rr ? ref_shift(o1, x1, sh1) : ref_shift(o0, x0, sh0);
    exp_fp = g_fp ? ref_shift(o1, x1, sh1) : ref_shift(o0, x0, sh0);
    #1;
    check("rr_grant", {rr_rdy1, rr_rdy0}, g_rr ? 2'b10 : 2'b01);
    check("fp_grant", {fp_rdy1, fp_rdy0}, g_fp ? 2'b10 : 2'b01);
    @(posedge clk);
    last_rr = g_rr;
    #1;
    op0 = 2'($urandom); d0 = $urandom; s0 = 5'($urandom);
    op1 = 2'($urandom); d1 = $urandom; s1 = 5'($urandom);
    if (!keep) begin
      v0 = 1'b0;
      v1 = 1'b0;
    end
    lat = 0;
    while (rr_rv !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", lat, 5);
    check("fp_rv", fp_rv, 1);
    for (int h = 0; h <= hold; h++) begin
      check("rr_data", rr_rdata, exp_rr);
      check("rr_id", rr_rid, g_rr);
      check("fp_data", fp_rdata, exp_fp);
      check("fp_id", fp_rid, g_fp);
      check("resp_rdy_low", {rr_rdy1, rr_rdy0, fp_rdy1, fp_rdy0}, 0);
      if (h < hold) begin
        @(posedge clk);
        #1;
        check("rr_rv_hold", rr_rv, 1);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("rr_idle_after_hs", rr_rv, 0);
    check("fp_idle_after_hs", fp_rv, 0);
  endtask

  initial begin
    bit gr, gf, saw;
    bit exp_rr_seq [3] = '{1'b0, 1'b1, 1'b0};
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b0;
    op0 = 2'b00; op1 = 2'b00; d0 = 32'd0; d1 = 32'd0; s0 = 5'd0; s1 = 5'd0;

    do_reset();

    txn(1, 0, 2'b10, 32'h8000_0000, 5'd31, 2'b00, 32'h0, 5'd0, 0, 0, gr, gf);
    check("sra_const", rr_rdata, 32'hFFFF_FFFF);
    check("sra_id", rr_rid, 0);

    txn(0, 1, 2'b00, 32'h0, 5'd0, 2'b00, 32'h0000_0001, 5'd4, 0, 0, gr, gf);
    check("sll_const", rr_rdata, 32'h0000_0010);
    txn(1, 0, 2'b01, 32'hF000_0000, 5'd28, 2'b00, 32'h0, 5'd0, 1, 0, gr, gf);
    check("srl_const", rr_rdata, 32'h0000_000F);
    txn(0, 1, 2'b00, 32'h0, 5'd0, 2'b11, 32'h1234_5678, 5'd9, 3, 0, gr, gf);
    check("pass_const", fp_rdata, 32'h1234_5678);
    txn(1, 0, 2'b00, 32'hDEAD_BEEF, 5'd0, 2'b00, 32'h0, 5'd0, 0, 0, gr, gf);
    check("shamt0_const", rr_rdata, 32'hDEAD_BEEF);
    txn(0, 1, 2'b00, 32'h0, 5'd0, 2'b10, 32'h7000_0000, 5'd3, 0, 0, gr, gf);

    v0 = 1'b1; op0 = 2'b00; d0 = $urandom; s0 = 5'($urandom);
    #1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_shift_rst");
    #2;
    rst = 1'b0;
    last_rr = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rr_rv !== 1'b0 || fp_rv !== 1'b0) saw = 1'b1;
    end
    check("no_resp_after_rst", saw, 0);
    txn(1, 0, 2'b00, 32'h0000_00FF, 5'd8, 2'b00, 32'h0, 5'd0, 0, 0, gr, gf);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      txn(1, 1, 2'($urandom), $urandom, 5'($urandom), 2'($urandom), $urandom, 5'($urandom), 0, 1, gr, gf);
      check("rr_id_seq", gr, exp_rr_seq[i]);
      check("fp_id_seq", gf, 0);
    end
    v0 = 1'b0;
    v1 = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bit a0, a1;
      a0 = 1'($urandom_range(0, 1));
      a1 = a0 ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(a0, a1, 2'($urandom), $urandom, 5'($urandom), 2'($urandom), $urandom, 5'($urandom),
          int'($urandom_range(0, 2)), 0, gr, gf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_controller.md
SHIFT_CONTROLLER -- requirements
Module: shift_controller

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 highest.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req0_valid_i, input, 1 bit: port 0 request valid.
REQ-005 SHALL have port req0_ready_o, output, 1 bit: port 0 request accepted this cycle.
REQ-006 SHALL have port req0_op_i, input, 2 bits: port 0 operation; 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-007 SHALL have port req0_data_i, input, 32 bits: port 0 operand.
REQ-008 SHALL have port req0_shamt_i, input, 5 bits: port 0 shift amount.
REQ-009 SHALL have ports req1_valid_i, req1_ready_o, req1_op_i, req1_data_i and req1_shamt_i, identical to the port 0 set, for requester 1.
REQ-010 SHALL have port resp_valid_o, output, 1 bit: result valid.
REQ-011 SHALL have port resp_ready_i, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port resp_id_o, output, 1 bit: index of the port that issued the result.
REQ-013 SHALL have port resp_data_o, output, 32 bits: shifted result.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and RESP.
REQ-015 SHALL, in IDLE, grant one valid port and drive reqN_ready_o = (state==IDLE) & grantN combinationally; acceptance = valid & ready.
REQ-016 SHALL, on the acceptance edge, latch op, data, shamt and id, load stage counter = 4, and enter SHIFT; inputs need not stay stable afterwards.
REQ-017 SHALL, in SHIFT, on each edge shift the work register by 2^cnt when shamt[cnt]=1, else hold it, then decrement cnt; the edge with cnt=0 enters RESP.
REQ-018 SHALL use shift semantics SLL zero-fill, SRL zero-fill and SRA sign-fill from bit 31; op 11 SHALL leave the work register unchanged.
REQ-019 SHALL have a fixed latency: resp_valid_o rises exactly 5 edges after the acceptance edge, including when shamt=0.
REQ-020 SHALL, in RESP, hold resp_valid_o=1 with resp_data_o and resp_id_o stable until resp_ready_i=1; the handshake edge returns the FSM to IDLE.
REQ-021 SHALL keep both reqN_ready_o=0 outside IDLE, so no acceptance can occur in the same cycle as a response handshake.
REQ-022 SHALL, when RR_EN=1 and both ports are valid, grant the port not granted last; a pointer updates only on acceptance.
REQ-023 SHALL, when RR_EN=0, grant port 0 whenever req0_valid_i=1.
REQ-024 SHALL drive resp_data_o from a register, never from a combinational path.

Reset
REQ-025 SHALL, on rst_i=1 at any time (including mid-SHIFT or RESP), immediately force state=IDLE, resp_valid_o=0, resp_data_o=0, resp_id_o=0, cnt=0 and last_grant=1 (port 0 wins first), and discard any in-flight transaction.
REQ-026 SHALL hold reqN_ready_o=0 while rst_i=1.

Structure
REQ-027 SHALL place op encodings, the FSM state enum and STAGES=5 in shared package shift_pkg.
REQ-028 SHALL instantiate one sub-module, shift_step: a combinational conditional shift of 32 bits by 2^k, where k is an input, with op-selected fill.

Verification
REQ-029 SHALL cover: port 0 SRA, data 0x80000000, shamt 31 -> resp_data_o 0xFFFFFFFF, resp_id_o 0, valid 5 edges after acceptance.
REQ-030 SHALL cover: SLL 0x00000001 shamt 4 -> 0x00000010; SRL 0xF0000000 shamt 28 -> 0x0000000F; op 11 0x12345678 -> 0x12345678.
REQ-031 SHALL cover: both ports continuously valid, RR_EN=1, three transactions -> resp_id_o sequence 0,1,0; with RR_EN=0 -> 0,0,0.
REQ-032 SHALL cover: resp_ready_i held 0 for 3 cycles in RESP -> outputs stable, both ready_o=0, then IDLE the edge after resp_ready_i=1.
REQ-033 SHALL cover: rst_i pulsed during the 3rd SHIFT cycle -> outputs 0 immediately, no response produced; the next request completes correctly.
